// File: rtl/game_pkg.sv
// Shared definitions for the game flow sequencer: state codes and BCD score limits.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_INIT  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_WIN   = 3'd4
  } game_state_e;

  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational 4-digit BCD adder with a 2-digit BCD increment, saturating at 9999.
module bcd_add_sat
  import game_pkg::*;
(
  input  logic [SCORE_W-1:0] a_i,
  input  logic [7:0]         inc_i,
  output logic [SCORE_W-1:0] sum_o
);

  logic [4:0]         carry;
  logic [4:0]         dsum;
  logic [3:0]         digit_b;
  logic [SCORE_W-1:0] sum_raw;

  always_comb begin
    carry    = '0;
    dsum     = '0;
    digit_b  = '0;
    sum_raw  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      digit_b = (i < 2) ? inc_i[i*4 +: 4] : 4'd0;
      dsum    = {1'b0, a_i[i*4 +: 4]} + {1'b0, digit_b} + {4'd0, carry[i]};
      if (dsum > 5'd9) begin
        dsum       = dsum - 5'd10;
        carry[i+1] = 1'b1;
      end else begin
        carry[i+1] = 1'b0;
      end
      sum_raw[i*4 +: 4] = dsum[3:0];
    end
    // A carry out of the thousands digit means the true sum exceeded 9999.
    sum_o = carry[4] ? BCD_MAX : sum_raw;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-level sequencer: start screen, judge reset hold, play, game-over/win overlay, BCD score.
// Define GAME_FLOW_HISCORE_EN to build the high-score register; otherwise hiscore is tied to 0.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int RST_HOLD   = 16,
  parameter int OVER_DELAY = 60,
  parameter int ENEMY_PTS  = 1,
  parameter int BOSS_PTS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter,
  input  logic               frame_tick,
  input  logic [3:0]         present_health,
  input  logic               enemy_kill,
  input  logic               boss_kill,
  output logic               play_en,
  output logic               end_en,
  output logic               win,
  output logic               game_rst,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] hiscore
);

  game_state_e        state_q, state_d;
  logic               enter_q;
  logic               enter_rise;
  logic [15:0]        hold_q, hold_d;
  logic [7:0]         frame_q, frame_d;
  logic               first_q, first_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] score_sum;
  logic [7:0]         score_inc;
  logic               play_en_q, end_en_q, win_q, game_rst_q;

  assign enter_rise = enter & ~enter_q;
  assign score_inc  = {boss_kill  ? 4'(BOSS_PTS)  : 4'd0,
                       enemy_kill ? 4'(ENEMY_PTS) : 4'd0};

  bcd_add_sat u_add (
    .a_i   (score_q),
    .inc_i (score_inc),
    .sum_o (score_sum)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    first_d = 1'b0;
    score_d = score_q;
    case (state_q)
      ST_START: begin
        if (enter_rise) begin
          state_d = ST_INIT;
          hold_d  = 16'(RST_HOLD - 1);
          score_d = '0;
        end
      end
      ST_INIT: begin
        if (hold_q == 16'd0) begin
          state_d = ST_PLAY;
          first_d = 1'b1;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      ST_PLAY: begin
        score_d = score_sum;
        // Health is stale on the first PLAY cycle while the judges leave reset.
        if (!first_q && present_health == 4'd0) begin
          state_d = ST_OVER;
          frame_d = '0;
        end else if (boss_kill) begin
          state_d = ST_WIN;
          frame_d = '0;
        end
      end
      ST_OVER, ST_WIN: begin
        if (frame_tick && frame_q < 8'(OVER_DELAY)) frame_d = frame_q + 8'd1;
        if (enter_rise && frame_q >= 8'(OVER_DELAY)) state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_START;
      enter_q    <= 1'b1;
      hold_q     <= '0;
      frame_q    <= '0;
      first_q    <= 1'b0;
      score_q    <= '0;
      play_en_q  <= 1'b0;
      end_en_q   <= 1'b0;
      win_q      <= 1'b0;
      game_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      enter_q    <= enter;
      hold_q     <= hold_d;
      frame_q    <= frame_d;
      first_q    <= first_d;
      score_q    <= score_d;
      play_en_q  <= state_d inside {ST_PLAY, ST_OVER, ST_WIN};
      end_en_q   <= state_d inside {ST_OVER, ST_WIN};
      win_q      <= (state_d == ST_WIN);
      game_rst_q <= state_d inside {ST_PLAY, ST_OVER, ST_WIN};
    end
  end

`ifdef GAME_FLOW_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;
  logic               hi_pend_q;

  // Compare one cycle after leaving PLAY so the final kill is already in score_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hiscore_q <= '0;
      hi_pend_q <= 1'b0;
    end else begin
      hi_pend_q <= (state_q == ST_PLAY) && (state_d inside {ST_OVER, ST_WIN});
      if (hi_pend_q && score_q > hiscore_q) hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign play_en  = play_en_q;
  assign end_en   = end_en_q;
  assign win      = win_q;
  assign game_rst = game_rst_q;
  assign score    = score_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl against a decimal-arithmetic reference model.
module tb_game_flow_ctrl;

  localparam int P_HOLD  = 16;
  localparam int P_DELAY = 60;
  localparam int P_EPTS  = 1;
  localparam int P_BPTS  = 1;

  logic        clk = 1'b0;
  logic        rst, enter, frame_tick, enemy_kill, boss_kill;
  logic [3:0]  present_health;
  logic        play_en, end_en, win, game_rst;
  logic [15:0] score, hiscore;
  logic [2:0]  state;
  logic [38:0] obs;

  int vectors = 0;
  int errors  = 0;

  // Reference model: state as plain codes, score as a decimal integer.
  int m_state, m_init, m_play, m_frames, m_score, m_hi;
  bit m_prev_en, m_pend;

  always #20 clk = ~clk;

  game_flow_ctrl #(
    .RST_HOLD   (P_HOLD),
    .OVER_DELAY (P_DELAY),
    .ENEMY_PTS  (P_EPTS),
    .BOSS_PTS   (P_BPTS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enter          (enter),
    .frame_tick     (frame_tick),
    .present_health (present_health),
    .enemy_kill     (enemy_kill),
    .boss_kill      (boss_kill),
    .play_en        (play_en),
    .end_en         (end_en),
    .win            (win),
    .game_rst       (game_rst),
    .score          (score),
    .state          (state),
    .hiscore        (hiscore)
  );

  assign obs = {state, play_en, end_en, win, game_rst, score, hiscore};

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [38:0] expv();
    logic [15:0] hi;
`ifdef GAME_FLOW_HISCORE_EN
    hi = to_bcd(m_hi);
`else
    hi = 16'h0000;
`endif
    expv = {3'(m_state), m_state >= 2, m_state >= 3, m_state == 4, m_state >= 2,
            to_bcd(m_score), hi};
  endfunction

  task automatic model_step(input bit rn, input bit en, input bit ft,
                            input logic [3:0] hp, input bit ek, input bit bk);
    bit rise;
    if (!rn) begin
      m_state = 0; m_init = 0; m_play = 0; m_frames = 0;
      m_score = 0; m_hi = 0; m_pend = 0; m_prev_en = 1;
      return;
    end
    rise = en && !m_prev_en;
    m_prev_en = en;
    if (m_pend) begin
      if (m_score > m_hi) m_hi = m_score;
      m_pend = 0;
    end
    case (m_state)
      0: if (rise) begin m_state = 1; m_init = 0; m_score = 0; end
      1: begin
        m_init++;
        if (m_init == P_HOLD) begin m_state = 2; m_play = 0; end
      end
      2: begin
        m_score += (ek ? P_EPTS : 0) + (bk ? 10 * P_BPTS : 0);
        if (m_score > 9999) m_score = 9999;
        m_play++;
        if (m_play > 1 && hp == 4'd0) begin m_state = 3; m_frames = 0; m_pend = 1; end
        else if (bk) begin m_state = 4; m_frames = 0; m_pend = 1; end
      end
      default: begin
        if (rise && m_frames >= P_DELAY) m_state = 0;
        else if (ft && m_frames < P_DELAY) m_frames++;
      end
    endcase
  endtask

  task automatic step(input bit rn, input bit en, input bit ft,
                      input logic [3:0] hp, input bit ek, input bit bk);
    rst = rn; enter = en; frame_tick = ft; present_health = hp;
    enemy_kill = ek; boss_kill = bk;
    @(posedge clk);
    model_step(rn, en, ft, hp, ek, bk);
    #1;
  endtask

  task automatic start_game(input logic [3:0] hp);
    step(1, 1, 0, hp, 0, 0);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL start_enter got=%h exp=%h", obs, expv()); end
    for (int i = 0; i < 40 && m_state != 2; i++) begin
      step(1, 0, 0, hp, 0, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL start_init got=%h exp=%h", obs, expv()); end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 4'd5, 1, 1);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL reset_values got=%h exp=%h", obs, expv()); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 4'd5, 0, 0);
      vectors++;
      if (state !== 3'd0) begin errors++; $display("FAIL enter_through_reset state=%0d exp=0", state); end
    end
    step(1, 0, 0, 4'd5, 0, 0);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL reset_idle got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_enter_held();
    int inits = 0;
    int low_cnt = 0;
    logic [2:0] prev = state;
    for (int i = 0; i < 100; i++) begin
      step(1, 1, 0, 4'd5, 0, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL enter_held cyc=%0d got=%h exp=%h", i, obs, expv()); end
      if (state == 3'd1 && prev != 3'd1) inits++;
      if (state == 3'd1 && game_rst === 1'b0) low_cnt++;
      prev = state;
    end
    vectors++;
    if (inits != 1) begin errors++; $display("FAIL init_entries got=%0d exp=1", inits); end
    vectors++;
    if (low_cnt != P_HOLD) begin errors++; $display("FAIL rst_hold got=%0d exp=%0d", low_cnt, P_HOLD); end
    vectors++;
    if (state !== 3'd2 || play_en !== 1'b1 || game_rst !== 1'b1) begin
      errors++; $display("FAIL play_entry state=%0d play_en=%b game_rst=%b exp 2/1/1", state, play_en, game_rst);
    end
    step(1, 0, 0, 4'd5, 0, 0);
  endtask

  task automatic test_score_win();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 4'd5, 1, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL enemy_kill got=%h exp=%h", obs, expv()); end
      step(1, 0, 0, 4'd5, 0, 0);
    end
    step(1, 0, 0, 4'd5, 1, 1);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL boss_kill got=%h exp=%h", obs, expv()); end
    vectors++;
    if (score !== 16'h0014 || state !== 3'd4 || end_en !== 1'b1 || win !== 1'b1) begin
      errors++; $display("FAIL win_result score=%h state=%0d end_en=%b win=%b exp 0014/4/1/1", score, state, end_en, win);
    end
    step(1, 0, 0, 4'd5, 1, 1);
    vectors++;
    if (score !== 16'h0014) begin errors++; $display("FAIL score_frozen got=%h exp=0014", score); end
  endtask

  task automatic test_over_delay();
    logic [2:0] end_state = state;
    for (int t = 1; t < P_DELAY; t++) begin
      step(1, 0, 1, 4'd5, 1, 0);
      step(1, 0, 0, 4'd5, 0, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL frame_count t=%0d got=%h exp=%h", t, obs, expv()); end
    end
    step(1, 1, 0, 4'd5, 0, 0);
    vectors++;
    if (state !== end_state || end_en !== 1'b1) begin
      errors++; $display("FAIL early_enter state=%0d exp=%0d", state, end_state);
    end
    step(1, 0, 1, 4'd5, 0, 0);
    step(1, 0, 0, 4'd5, 0, 0);
    step(1, 1, 0, 4'd5, 0, 0);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL late_enter got=%h exp=%h", obs, expv()); end
    vectors++;
    if (state !== 3'd0 || play_en !== 1'b0 || game_rst !== 1'b0 || end_en !== 1'b0) begin
      errors++; $display("FAIL back_to_start state=%0d play_en=%b game_rst=%b exp 0/0/0", state, play_en, game_rst);
    end
    step(1, 0, 0, 4'd5, 0, 0);
  endtask

  task automatic test_health_first_cycle();
    step(0, 0, 0, 4'd5, 0, 0);
    vectors++;
    if (hiscore !== 16'h0000) begin errors++; $display("FAIL hiscore_rst got=%h exp=0000", hiscore); end
    step(1, 0, 0, 4'd5, 0, 0);
    start_game(4'd0);
    step(1, 0, 0, 4'd0, 0, 0);
    vectors++;
    if (state !== 3'd2 || obs !== expv()) begin errors++; $display("FAIL health_first got=%h exp=%h", obs, expv()); end
    for (int i = 0; i < 2; i++) step(1, 0, 0, 4'd3, 1, 0);
    step(1, 0, 0, 4'd0, 0, 1);
    vectors++;
    if (state !== 3'd3 || win !== 1'b0 || score !== 16'h0012) begin
      errors++; $display("FAIL over_boss state=%0d win=%b score=%h exp 3/0/0012", state, win, score);
    end
    step(1, 0, 0, 4'd5, 0, 0);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL hiscore_game1 got=%h exp=%h", obs, expv()); end
  endtask

  task automatic test_hiscore();
    start_game(4'd7);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 4'd7, 1, 0);
    step(1, 0, 0, 4'd0, 0, 0);
    step(1, 0, 0, 4'd0, 0, 0);
    vectors++;
    if (obs !== expv()) begin errors++; $display("FAIL hiscore_game2 got=%h exp=%h", obs, expv()); end
`ifdef GAME_FLOW_HISCORE_EN
    vectors++;
    if (hiscore !== 16'h0012 || score !== 16'h0005) begin
      errors++; $display("FAIL hiscore_keep hiscore=%h score=%h exp 0012/0005", hiscore, score);
    end
`endif
    test_over_delay();
    step(0, 0, 0, 4'd5, 0, 0);
    vectors++;
    if (hiscore !== 16'h0000 || score !== 16'h0000) begin
      errors++; $display("FAIL hiscore_clear hiscore=%h score=%h exp 0000/0000", hiscore, score);
    end
    step(1, 0, 0, 4'd5, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      bit rn = ($urandom_range(0, 599) != 0);
      bit en = ($urandom_range(0, 7) == 0);
      bit ft = ($urandom_range(0, 3) == 0);
      logic [3:0] hp = ($urandom_range(0, 39) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      bit ek = ($urandom_range(0, 3) == 0);
      bit bk = ($urandom_range(0, 59) == 0);
      step(rn, en, ft, hp, ek, bk);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL random cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 4'd5, 0, 0);
    step(1, 0, 0, 4'd5, 0, 0);
    start_game(4'd9);
    for (int i = 0; i < 9995; i++) begin
      step(1, 0, 0, 4'd9, 1, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL count_up cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
    vectors++;
    if (score !== 16'h9995) begin errors++; $display("FAIL preload got=%h exp=9995", score); end
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 4'd9, 1, 0);
      vectors++;
      if (obs !== expv()) begin errors++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, obs, expv()); end
    end
    vectors++;
    if (score !== 16'h9999 || state !== 3'd2) begin
      errors++; $display("FAIL saturate_final score=%h state=%0d exp 9999/2", score, state);
    end
  endtask

  initial begin
    m_state = 0; m_init = 0; m_play = 0; m_frames = 0;
    m_score = 0; m_hi = 0; m_pend = 0; m_prev_en = 1;
    test_reset();
    test_enter_held();
    test_score_win();
    test_over_delay();
    test_health_first_cycle();
    test_over_delay();
    test_hiscore();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Game-level sequencer feeding the top-level pixel-select logic.
- Produces `play_en` (start screen vs. game), `end_en` (game-over/win overlay), a synchronous active-low reset for all game-element judges, and a 4-digit BCD score.
- Consumes PS2 enter, health from the player hit-judge, and kill pulses from the enemy and boss hit-judges.
- Runs on the 25.175 MHz pixel clock.

Parameters:
- RST_HOLD, 16: cycles `game_rst` is held low in INIT (min 2).
- OVER_DELAY, 60: frames after entering OVER/WIN before enter is accepted (1..255).
- ENEMY_PTS, 1: BCD points per enemy kill (single digit, 0..9).
- BOSS_PTS, 1: BCD tens-digit points per boss kill (adds BOSS_PTS*10).

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- rst  in  1  synchronous, active-low reset
- enter  in  1  PS2 enter key level
- frame_tick  in  1  one-cycle pulse per frame (start of vsync)
- present_health  in  4  player health from hit-judge
- enemy_kill  in  1  one-cycle pulse, enemy destroyed
- boss_kill  in  1  one-cycle pulse, boss destroyed
- play_en  out  1  1 = game screen, 0 = start screen
- end_en  out  1  game-over/win overlay enable
- win  out  1  valid while end_en = 1; 1 = boss destroyed
- game_rst  out  1  sync active-low reset to game-element judges
- score  out  16  BCD score, digit 3 = MSD
- state  out  3  current state code, for debug/overlay select
- hiscore  out  16  BCD high score (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst). All outputs are registered.
- Reset values: state = START (0), play_en = 0, end_en = 0, win = 0, game_rst = 0, score = 0, hiscore = 0, counters = 0.
- Enter edge detect: `enter_d` is registered; `enter_rise = enter & ~enter_d`. Held enter gives exactly one event. `enter_d` resets to 1, so enter held through reset does not trigger.
- State codes: START = 0, INIT = 1, PLAY = 2, OVER = 3, WIN = 4.
- START: `game_rst` = 0, `play_en` = 0. On `enter_rise` go to INIT.
- INIT:
  - On entry: clear score, load hold counter.
  - `game_rst` = 0 for exactly RST_HOLD cycles, then go to PLAY. `game_rst` rises on the first PLAY cycle.
- PLAY:
  - `play_en` = 1, `game_rst` = 1.
  - `present_health` is ignored on the first PLAY cycle (judge reset latency). From the second cycle, `present_health == 0` goes to OVER.
  - Otherwise `boss_kill` goes to WIN.
  - Health 0 and `boss_kill` in the same cycle: OVER wins; the boss points are still added.
- Scoring:
  - Score updates only in PLAY, including the cycle that exits PLAY.
  - `enemy_kill` adds ENEMY_PTS; `boss_kill` adds BOSS_PTS*10. Both in the same cycle add the sum.
  - Score saturates at 9999 (no wrap). Update appears on `score` 1 cycle after the pulse.
- OVER / WIN:
  - `play_en` = 1, `end_en` = 1, `win` = 0 in OVER and 1 in WIN. Score frozen. `game_rst` stays 1 (scene frozen by judges).
  - A frame counter clears on entry and counts `frame_tick` up to OVER_DELAY.
  - `enter_rise` before the count reaches OVER_DELAY is ignored; at or after it, go to START.
- Kill pulses in START, INIT, OVER or WIN are ignored.
- `rst` low in any state returns to reset values on the next edge. Score is lost.

Optional Feature:
- Macro: GAME_FLOW_HISCORE_EN.
- Defined: on each transition into OVER or WIN, if the (post-update) score is greater than `hiscore`, `hiscore` loads it one cycle later. `hiscore` is cleared only by `rst`, never by INIT.
- Undefined: the `hiscore` port remains, tied to 0; no comparator or register is built.

Decomposition:
- Shared package `game_pkg` holds:
  - state enum (START..WIN, 3-bit);
  - BCD score width constant SCORE_W = 16;
  - BCD_MAX = 16'h9999.
- One sub-module: `bcd_add_sat`. It is combinational: 4-digit BCD plus 8-bit BCD increment (two digits), saturating at 9999, with per-digit carry.

Test Plan:
- Reset, then enter held high for 100 cycles:
  - exactly one INIT entry;
  - `game_rst` low for 16 cycles, then PLAY with `play_en` = 1;
  - no second INIT.
- In PLAY, 3 `enemy_kill` pulses, then `boss_kill` together with `enemy_kill` → score 16'h0014, state WIN, `end_en` = 1, `win` = 1.
- Preload score to 9995, then 7 `enemy_kill` pulses → score saturates at 16'h9999.
- `present_health` = 0 on the first PLAY cycle: no OVER. Health = 0 on a later cycle together with `boss_kill` → OVER, `win` = 0, boss points added.
- In OVER, `enter_rise` after 59 frame_ticks → ignored. After the 60th tick → START, `play_en` = 0, `game_rst` = 0.
- With GAME_FLOW_HISCORE_EN:
  - game 1 ends at 0012 → `hiscore` = 0012;
  - game 2 ends at 0005 → `hiscore` stays 0012;
  - `rst` → `hiscore` = 0.
